// File: rtl/backend_redirect_ctrl.sv
// Backend redirect arbiter: picks the oldest mispredict/ordering violation, offers it to the
// frontend and pulses flush_o on acceptance. Define MEM_REDIRECT_EN to enable the mem_* source.
module backend_redirect_ctrl #(
  parameter int unsigned ROB_WIDTH    = 6,
  parameter int unsigned FSQ_WIDTH    = 5,
  parameter int unsigned VADDR_SIZE   = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_en,
  input  logic [ROB_WIDTH:0]    br_rob_idx,
  input  logic [FSQ_WIDTH-1:0]  br_fsq_idx,
  input  logic [VADDR_SIZE-1:0] br_target,
  input  logic                  mem_en,
  input  logic [ROB_WIDTH:0]    mem_rob_idx,
  input  logic [FSQ_WIDTH-1:0]  mem_fsq_idx,
  input  logic [VADDR_SIZE-1:0] mem_target,
  input  logic                  exc_flush,
  output logic                  redir_valid,
  input  logic                  redir_ready,
  output logic [ROB_WIDTH:0]    redir_rob_idx,
  output logic [FSQ_WIDTH-1:0]  redir_fsq_idx,
  output logic [VADDR_SIZE-1:0] redir_target,
  output logic                  redir_src,
  output logic                  flush_o,
  output logic                  busy
);

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {StIdle, StHold, StDrain} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ROB_WIDTH:0]    rob_q, rob_d;
  logic [FSQ_WIDTH-1:0]  fsq_q, fsq_d;
  logic [VADDR_SIZE-1:0] tgt_q, tgt_d;
  logic                  src_q, src_d;

  // MSB of a robIdx is the wrap flag; differing flags invert the index ordering.
  function automatic logic is_older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH]) begin
      return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    end
    return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

  logic mem_take;
`ifdef MEM_REDIRECT_EN
  assign mem_take = mem_en & (~br_en | is_older(mem_rob_idx, br_rob_idx));
`else
  logic unused_mem;
  assign unused_mem = ^{mem_en, mem_rob_idx, mem_fsq_idx, mem_target};
  assign mem_take   = 1'b0;
`endif

  logic                  cand_valid;
  logic [ROB_WIDTH:0]    cand_rob;
  logic [FSQ_WIDTH-1:0]  cand_fsq;
  logic [VADDR_SIZE-1:0] cand_tgt;
  logic                  cand_older;

  always_comb begin
    cand_valid = br_en | mem_take;
    cand_rob   = mem_take ? mem_rob_idx : br_rob_idx;
    cand_fsq   = mem_take ? mem_fsq_idx : br_fsq_idx;
    cand_tgt   = mem_take ? mem_target  : br_target;
    // rob_q holds the offered entry in HOLD and the issued entry in DRAIN.
    cand_older = cand_valid & is_older(cand_rob, rob_q);
  end

  always_comb begin
    logic capture;
    capture = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    rob_d   = rob_q;
    fsq_d   = fsq_q;
    tgt_d   = tgt_q;
    src_d   = src_q;

    if (exc_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: capture = cand_valid;
        StHold: begin
          if (cand_older) begin
            capture = 1'b1;
          end else if (redir_ready) begin
            state_d = StDrain;
            cnt_d   = DrainLoad;
          end
        end
        StDrain: begin
          if (cand_older) begin
            capture = 1'b1;
          end else begin
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            if (cnt_d == 4'd0) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (capture) begin
      state_d = StHold;
      cnt_d   = '0;
      rob_d   = cand_rob;
      fsq_d   = cand_fsq;
      tgt_d   = cand_tgt;
      src_d   = mem_take;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rob_q   <= '0;
      fsq_q   <= '0;
      tgt_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rob_q   <= rob_d;
      fsq_q   <= fsq_d;
      tgt_q   <= tgt_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    redir_valid   = (state_q == StHold);
    flush_o       = redir_valid & redir_ready & ~exc_flush;
    busy          = (state_q != StIdle);
    redir_rob_idx = rob_q;
    redir_fsq_idx = fsq_q;
    redir_target  = tgt_q;
    redir_src     = src_q;
  end

endmodule

// File: tb/tb_backend_redirect_ctrl.sv
// Directed + random bench for backend_redirect_ctrl against a behavioural redirect model.
module tb_backend_redirect_ctrl;

`ifdef MEM_REDIRECT_EN
  localparam bit MemOn = 1'b1;
`else
  localparam bit MemOn = 1'b0;
`endif
  localparam int Drain = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_en = 1'b0, mem_en = 1'b0, exc_flush = 1'b0, redir_ready = 1'b0;
  logic [6:0]  br_rob = '0, mem_rob = '0;
  logic [4:0]  br_fsq = '0, mem_fsq = '0;
  logic [31:0] br_tgt = '0, mem_tgt = '0;
  logic        redir_valid, redir_src, flush_o, busy;
  logic [6:0]  redir_rob_idx;
  logic [4:0]  redir_fsq_idx;
  logic [31:0] redir_target;

  int total = 0;
  int bad = 0;

  backend_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .br_en        (br_en),
    .br_rob_idx   (br_rob),
    .br_fsq_idx   (br_fsq),
    .br_target    (br_tgt),
    .mem_en       (mem_en),
    .mem_rob_idx  (mem_rob),
    .mem_fsq_idx  (mem_fsq),
    .mem_target   (mem_tgt),
    .exc_flush    (exc_flush),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_rob_idx(redir_rob_idx),
    .redir_fsq_idx(redir_fsq_idx),
    .redir_target (redir_target),
    .redir_src    (redir_src),
    .flush_o      (flush_o),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: an offered entry, a count of remaining drain cycles, and the payload.
  bit          m_held = 0;
  int          m_drain = 0;
  int          m_rob = 0;
  int          m_fsq = 0;
  logic [31:0] m_tgt = '0;
  bit          m_src = 0;

  // a is older than b when (a - b) modulo 128 lies strictly above half the ring.
  function automatic bit m_older(input int a, input int b);
    return ((a - b) & 127) > 64;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_drain = 0; m_rob = 0; m_fsq = 0; m_tgt = '0; m_src = 0;
  endtask

  task automatic idle_in();
    br_en = 0; mem_en = 0; exc_flush = 0; redir_ready = 0;
  endtask

  // Check outputs against the model at the negedge, advance the model, return at posedge+1.
  task automatic cycle();
    bit c_v, c_s, take_mem;
    int c_rob, c_fsq;
    logic [31:0] c_tgt;
    @(negedge clk);
    check("valid", 64'(redir_valid), 64'(m_held));
    check("flush", 64'(flush_o), 64'(m_held && redir_ready && !exc_flush));
    check("busy",  64'(busy), 64'(m_held || m_drain > 0));
    if (m_held) begin
      check("rob", 64'(redir_rob_idx), 64'(m_rob));
      check("fsq", 64'(redir_fsq_idx), 64'(m_fsq));
      check("tgt", 64'(redir_target), 64'(m_tgt));
      check("src", 64'(redir_src), 64'(m_src));
    end
    take_mem = MemOn && mem_en && (!br_en || m_older(int'(mem_rob), int'(br_rob)));
    c_v   = br_en || take_mem;
    c_s   = take_mem;
    c_rob = take_mem ? int'(mem_rob) : int'(br_rob);
    c_fsq = take_mem ? int'(mem_fsq) : int'(br_fsq);
    c_tgt = take_mem ? mem_tgt : br_tgt;
    if (exc_flush) begin
      m_held = 0; m_drain = 0;
    end else if ((m_held || m_drain > 0) ? (c_v && m_older(c_rob, m_rob)) : c_v) begin
      m_held = 1; m_drain = 0; m_rob = c_rob; m_fsq = c_fsq; m_tgt = c_tgt; m_src = c_s;
    end else if (m_held) begin
      if (redir_ready) begin
        m_held = 0; m_drain = Drain;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [6:0] r, input logic [31:0] t);
    br_en = 1; br_rob = r; br_fsq = r[4:0] ^ 5'h15; br_tgt = t;
  endtask

  task automatic mem(input logic [6:0] r, input logic [31:0] t);
    mem_en = 1; mem_rob = r; mem_fsq = r[4:0] ^ 5'h0a; mem_tgt = t;
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(redir_valid), 64'd0);
    check("rst_flush", 64'(flush_o), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_rob",   64'(redir_rob_idx), 64'd0);
    check("rst_tgt",   64'(redir_target), 64'd0);
    check("rst_src",   64'(redir_src), 64'd0);
    #10 rst = 1;
    @(posedge clk); #1;

    // Simple issue with immediate acceptance.
    idle_in(); br(7'h05, 32'h8000_0100); redir_ready = 1; cycle();
    check("t28_valid", 64'(redir_valid), 64'd1);
    check("t28_rob", 64'(redir_rob_idx), 64'h05);
    check("t28_tgt", 64'(redir_target), 64'h8000_0100);
    idle_in(); redir_ready = 1; cycle();
    check("t28_drain_busy", 64'(busy), 64'd1);
    idle_in(); cycle(); cycle();
    check("t28_idle", 64'(busy), 64'd0);

    // Older replacement under backpressure; younger dropped.
    br(7'h0A, 32'h1000_0000); cycle();
    idle_in(); br(7'h03, 32'h1000_0030); cycle();
    check("t29_replace", 64'(redir_rob_idx), 64'h03);
    idle_in(); br(7'h0C, 32'h1000_00c0); cycle();
    check("t29_drop", 64'(redir_rob_idx), 64'h03);
    idle_in(); redir_ready = 1; cycle();
    idle_in(); cycle(); cycle();

    // Wrap-around: 0x3E (flag 0) stays older than 0x41 (flag 1).
    br(7'h3E, 32'h2000_0000); cycle();
    idle_in(); mem(7'h41, 32'h2000_0041); cycle();
    check("t30_hold", 64'(redir_rob_idx), 64'h3E);
    check("t30_src", 64'(redir_src), 64'd0);
    idle_in(); redir_ready = 1; cycle();
    idle_in(); cycle(); cycle();

    // Same-cycle tie: branch wins.
    br(7'h10, 32'h3000_0b00); mem(7'h10, 32'h3000_0e00); cycle();
    check("t31_src", 64'(redir_src), 64'd0);
    check("t31_tgt", 64'(redir_target), 64'h3000_0b00);
    idle_in(); redir_ready = 1; cycle();
    idle_in(); cycle(); cycle();

    // Drain filtering and re-capture of an older branch.
    br(7'h08, 32'h4000_0008); cycle();
    idle_in(); redir_ready = 1; cycle();
    idle_in(); br(7'h09, 32'h4000_0009); cycle();
    check("t32_discard", 64'(redir_valid), 64'd0);
    idle_in(); br(7'h07, 32'h4000_0007); cycle();
    check("t32_capture", 64'(redir_rob_idx), 64'h07);
    idle_in(); redir_ready = 1; cycle();
    idle_in(); cycle(); cycle();

    // Exception flush in HOLD suppresses the handshake.
    br(7'h20, 32'h5000_0020); cycle();
    idle_in(); redir_ready = 1; exc_flush = 1; cycle();
    check("t33_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-DRAIN.
    idle_in(); br(7'h22, 32'h5000_0022); cycle();
    idle_in(); redir_ready = 1; cycle();
    idle_in();
    #2 rst = 0;
    #1;
    check("t33_rst_busy", 64'(busy), 64'd0);
    check("t33_rst_valid", 64'(redir_valid), 64'd0);
    check("t33_rst_flush", 64'(flush_o), 64'd0);
    check("t33_rst_rob", 64'(redir_rob_idx), 64'd0);
    model_reset();
    rst = 1;
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      br_en       = ($urandom_range(0, 99) < 30);
      mem_en      = ($urandom_range(0, 99) < 30);
      br_rob      = 7'($urandom_range(0, 127));
      mem_rob     = ($urandom_range(0, 3) == 0) ? br_rob : 7'($urandom_range(0, 127));
      br_fsq      = 5'($urandom);
      mem_fsq     = 5'($urandom);
      br_tgt      = $urandom;
      mem_tgt     = $urandom;
      redir_ready = ($urandom_range(0, 99) < 45);
      exc_flush   = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/backend_redirect_ctrl.md
BACKEND_REDIRECT_CTRL -- requirements
Module: backend_redirect_ctrl

Interface
REQ-001 Parameters SHALL be: ROB_WIDTH, default 6, ROB index bits (each robIdx is ROB_WIDTH+1 bits, where the MSB is the wrap flag); FSQ_WIDTH, default 5, fetch-target-queue index bits; VADDR_SIZE, default 32, target width; DRAIN_CYCLES, default 2, post-issue window length (range 1..15).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 br_en / br_rob_idx / br_fsq_idx / br_target  in  1 / ROB_WIDTH+1 / FSQ_WIDTH / VADDR_SIZE  oldest ALU branch mispredict of this cycle.
REQ-005 mem_en / mem_rob_idx / mem_fsq_idx / mem_target  in  1 / ROB_WIDTH+1 / FSQ_WIDTH / VADDR_SIZE  memory-ordering violation; refetch at mem_target.
REQ-006 exc_flush  in  1  commit-stage full flush.
REQ-007 redir_valid  out  1  redirect offered to frontend.
REQ-008 redir_ready  in  1  frontend accepts redirect.
REQ-009 redir_rob_idx / redir_fsq_idx / redir_target / redir_src  out  ROB_WIDTH+1 / FSQ_WIDTH / VADDR_SIZE / 1  payload; redir_src=0 means branch, 1 means memory.
REQ-010 flush_o  out  1  one-cycle pulse that kills backend instructions younger than redir_rob_idx.
REQ-011 busy  out  1  high whenever state is not IDLE.

Function
REQ-012 Age compare: a SHALL be older than b when the wrap flags are equal and a.idx < b.idx, or when the wrap flags differ and a.idx > b.idx.
REQ-013 Same-cycle candidate select SHALL pick the older of br and mem; on equal robIdx, br SHALL win.
REQ-014 FSM states SHALL be IDLE, HOLD and DRAIN; state and payload SHALL be registered.
REQ-015 IDLE: a valid candidate SHALL be captured, and the next state SHALL be HOLD; redir_valid SHALL assert the cycle after capture (latency 1).
REQ-016 HOLD: redir_valid SHALL be 1; a new candidate strictly older than the held one SHALL replace the payload; equal-age or younger candidates SHALL be dropped.
REQ-017 The payload SHALL change while redir_valid=1 and redir_ready=0 only by the older-replacement rule in REQ-016.
REQ-018 Handshake: redir_valid & redir_ready SHALL assert flush_o in that same cycle; the next state SHALL be DRAIN, with the counter loaded to DRAIN_CYCLES.
REQ-019 If an older candidate arrives in the handshake cycle, the handshake SHALL complete on the old payload, and the older candidate SHALL be captured into HOLD instead of entering DRAIN.
REQ-020 DRAIN: redir_valid SHALL be 0; candidates equal to or younger than the issued robIdx SHALL be discarded; a strictly older candidate SHALL be captured, and the next state SHALL be HOLD; otherwise the counter SHALL decrement, and the state SHALL go to IDLE when it reaches 0.
REQ-021 The counter SHALL be 4 bits and saturating; it SHALL never wrap below 0.
REQ-022 exc_flush SHALL take highest priority in any state: next state IDLE, counter 0, and all same-cycle candidates discarded; flush_o SHALL NOT pulse.
REQ-023 flush_o SHALL be high for exactly one cycle per accepted redirect.

Reset
REQ-024 On rst=0, the block SHALL immediately enter IDLE with: redir_valid=0, flush_o=0, busy=0, counter=0, all payload registers 0, redir_src=0.
REQ-025 Reset asserted mid-HOLD or mid-DRAIN SHALL abort the redirect with no flush_o pulse.

Configuration
REQ-026 Macro MEM_REDIRECT_EN: when defined, the mem_* inputs SHALL participate as specified above.
REQ-027 When MEM_REDIRECT_EN is undefined, mem_* SHALL be ignored, redir_src SHALL be tied to 0, and the br path timing SHALL be unchanged.

Verification
REQ-028 Simple issue: br_en=1, rob=0x05, target=0x8000_0100, redir_ready=1 -> the next cycle shows redir_valid=1, payload rob=0x05, target=0x8000_0100, flush_o=1; then 2 cycles of busy; then IDLE.
REQ-029 Replacement under backpressure: hold rob=0x0A with redir_ready=0, then br rob=0x03 arrives -> payload becomes 0x03; rob=0x0C arriving later is dropped.
REQ-030 Wrap-around: held rob=0x3E (flag 0), then mem rob=0x41 (flag 1, idx 1) arrives -> the held entry stays, because 0x3E is older.
REQ-031 Same-cycle tie: br and mem both with rob=0x10 -> redir_src=0, br payload issued.
REQ-032 Drain: after issuing rob=0x08, a br at rob=0x09 in DRAIN is discarded, while a br at rob=0x07 is captured and a second flush_o pulse follows.
REQ-033 Flush and reset: exc_flush in HOLD with redir_ready=1 -> no flush_o, IDLE next cycle; rst=0 mid-DRAIN -> all outputs 0 asynchronously.
